// File: rtl/div_fifo_harness.sv
// FIFO-to-divider harness: pops {dividend, divisor}, issues to an external divider, pushes
// {remainder, quotient}. Optional divide-by-zero bypass is compiled in with DIV_ZERO_BYPASS_EN.
module div_fifo_harness #(
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2*W-1:0]   idata,
  input  logic             rdy,
  input  logic             not_full,
  output logic             pop,
  output logic             push,
  output logic [2*W-1:0]   odata,
  output logic             dut_valid,
  output logic [W-1:0]     dut_dividend,
  output logic [W-1:0]     dut_divisor,
  input  logic             dut_done,
  input  logic [W-1:0]     dut_quotient,
  input  logic [W-1:0]     dut_remainder,
  output logic             err_timeout,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int unsigned WdW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StIssue = 3'd2,
    StWait  = 3'd3,
    StHold  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             pop_q, pop_d;
  logic             push_q, push_d;
  logic [2*W-1:0]   odata_q, odata_d;
  logic [W-1:0]     dvd_q, dvd_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WdW-1:0]   wd_q, wd_d;

  logic wd_expired, div_zero, bypass_evt, wait_evt;

  assign wd_expired = (wd_q == WdW'(TIMEOUT - 1));
`ifdef DIV_ZERO_BYPASS_EN
  assign div_zero = (dvs_q == '0);
`else
  assign div_zero = 1'b0;
`endif
  assign bypass_evt = (state_q == StIssue) && div_zero;
  assign wait_evt   = (state_q == StWait) && (dut_done || wd_expired);

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // LOAD spans two cycles: the pop cycle, then the cycle idata is valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (rdy && not_full) state_d = StLoad;
      StLoad:  if (!pop_q) state_d = StIssue;
      StIssue: begin
        if (bypass_evt) state_d = not_full ? StIdle : StHold;
        else            state_d = StWait;
      end
      StWait:  if (wait_evt) state_d = not_full ? StIdle : StHold;
      StHold:  if (not_full) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pop_d   = 1'b0;
    push_d  = 1'b0;
    odata_d = odata_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    err_d   = err_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q + CNT_W'(push_q);
    case (state_q)
      StIdle:  pop_d = rdy && not_full;
      StLoad:  if (!pop_q) {dvd_d, dvs_d} = idata;
      StIssue: begin
        wd_d = '0;
        if (bypass_evt) begin
          odata_d = {dvd_q, {W{1'b1}}};
          push_d  = not_full;
        end
      end
      StWait: begin
        wd_d = wd_q + 1'b1;
        // A coincident dut_done takes priority over the watchdog.
        if (dut_done) begin
          odata_d = {dut_remainder, dut_quotient};
          push_d  = not_full;
        end else if (wd_expired) begin
          odata_d = '1;
          err_d   = 1'b1;
          push_d  = not_full;
        end
      end
      StHold:  push_d = not_full;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pop_q   <= 1'b0;
      push_q  <= 1'b0;
      odata_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      wd_q    <= '0;
    end else begin
      pop_q   <= pop_d;
      push_q  <= push_d;
      odata_q <= odata_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
    end
  end

  assign pop          = pop_q;
  assign push         = push_q;
  assign odata        = odata_q;
  assign dut_valid    = (state_q == StIssue) && !div_zero;
  assign dut_dividend = dvd_q;
  assign dut_divisor  = dvs_q;
  assign err_timeout  = err_q;
  assign txn_cnt      = cnt_q;

endmodule

// File: tb/tb_div_fifo_harness.sv
// Scoreboard bench for div_fifo_harness: FIFO and divider models at negedge, expected results
// computed from plain division when each word is queued.
module tb_div_fifo_harness;

  localparam int TO = 8;
`ifdef DIV_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, rdy, not_full, pop, push, dut_valid, dut_done, err_timeout;
  logic [15:0] idata, odata, txn_cnt;
  logic [7:0]  dut_dividend, dut_divisor, dut_quotient, dut_remainder;

  always #5 clk = ~clk;

  div_fifo_harness #(.W(8), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .idata(idata), .rdy(rdy), .not_full(not_full), .pop(pop),
    .push(push), .odata(odata), .dut_valid(dut_valid), .dut_dividend(dut_dividend),
    .dut_divisor(dut_divisor), .dut_done(dut_done), .dut_quotient(dut_quotient),
    .dut_remainder(dut_remainder), .err_timeout(err_timeout), .txn_cnt(txn_cnt)
  );

  typedef struct {
    logic [15:0] data;
    int          lat;
    bit          tmo;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] in_q[$];
  int          dq[$];
  int          vq[$];
  int          cyc = 0, errors = 0, checks = 0;
  int          vcnt = 0, pop_cnt = 0, push_cnt = 0, div_cnt = 0, npush = 0;
  int          last_pop_cyc = 0, last_push_cyc = 0, l_tmp;
  bit          sticky = 0, nf_dip = 0, valid_prev = 0;
  logic [15:0] w_tmp;
  exp_t        e_tmp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference: what the harness must deliver for operands a/b given divider latency l (0=never).
  task automatic send(input logic [7:0] a, input logic [7:0] b, input int l);
    exp_t e;
    bit   byp_zero;
    byp_zero = BYP && (b == 8'd0);
    e.tmo = !byp_zero && (l == 0 || l > TO);
    if (byp_zero) begin
      e.data = {a, 8'hFF};
      e.lat  = 3;
    end else if (e.tmo) begin
      e.data = 16'hFFFF;
      e.lat  = 3 + TO;
    end else begin
      e.data = (b == 8'd0) ? {a, 8'hFF} : {a % b, a / b};
      e.lat  = 3 + l;
    end
    if (!byp_zero) dq.push_back(l);
    sb.push_back(e);
    in_q.push_back({a, b});
  endtask

  // Divider, input FIFO and output monitor, in a fixed order each negedge.
  always @(negedge clk) begin
    dut_done = 1'b0;
    if (div_cnt > 0) begin
      div_cnt--;
      if (div_cnt == 0) begin
        dut_done = 1'b1;
        if (dut_divisor == 8'd0) begin
          dut_quotient  = 8'hFF;
          dut_remainder = dut_dividend;
        end else begin
          dut_quotient  = dut_dividend / dut_divisor;
          dut_remainder = dut_dividend % dut_divisor;
        end
      end
    end
    if (dut_valid) begin
      vcnt++;
      chk("valid_width", 32'(valid_prev), 32'd0);
      if (vq.size() == 0 || dq.size() == 0) fail("unexpected_valid");
      else begin
        chk("valid_lat", cyc - vq.pop_front(), 32'd2);
        l_tmp = dq.pop_front();
        if (l_tmp > 0) div_cnt = l_tmp;
      end
    end
    valid_prev = dut_valid;

    if (pop) begin
      pop_cnt++;
      if (in_q.size() == 0) fail("pop_on_empty");
      else begin
        w_tmp        = in_q.pop_front();
        idata        = w_tmp;
        last_pop_cyc = cyc;
        nf_dip       = 1'b0;
        if (!(BYP && w_tmp[7:0] == 8'd0)) vq.push_back(cyc);
      end
    end
    rdy = (in_q.size() != 0);
    if (!not_full) nf_dip = 1'b1;

    if (push) begin
      push_cnt++;
      last_push_cyc = cyc;
      if (sb.size() == 0) fail("unexpected_push");
      else begin
        e_tmp = sb.pop_front();
        npush++;
        if (e_tmp.tmo) sticky = 1'b1;
        chk("odata", 32'(odata), 32'(e_tmp.data));
        chk("err_timeout", 32'(err_timeout), 32'(sticky));
        if (nf_dip) chk("push_lat_min", 32'(cyc - last_pop_cyc >= e_tmp.lat), 32'd1);
        else        chk("push_lat", cyc - last_pop_cyc, e_tmp.lat);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, input bit rnd_nf);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      if (rnd_nf) not_full = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    not_full = 1'b1;
    if (sb.size() != 0) fail("drain_timeout");
    repeat (3) step();
  endtask

  task automatic wait_valid(input int v0);
    int n = 0;
    while (vcnt == v0 && n < 50) begin
      step();
      n++;
    end
    if (vcnt == v0) fail("valid_timeout");
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ctrl"}, 32'({pop, push, dut_valid, err_timeout}), 32'd0);
    chk({nm, "_odata"}, 32'(odata), 32'd0);
    chk({nm, "_operands"}, 32'({dut_dividend, dut_divisor}), 32'd0);
    chk({nm, "_txn_cnt"}, 32'(txn_cnt), 32'd0);
  endtask

  initial begin
    int v0, p0, rise;
    logic [7:0] a, b;
    int r, l;
    reset = 1'b1;
    not_full = 1'b1;
    rdy = 1'b0;
    idata = '0;
    dut_done = 1'b0;
    dut_quotient = '0;
    dut_remainder = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reset_vals("reset");

    // Single transaction, 3-cycle divider.
    send(8'h64, 8'h07, 3);
    drain(100, 1'b0);
    chk("txn_cnt_1", 32'(txn_cnt), 32'(npush));
    chk("pops_1", pop_cnt, 32'd1);

    // Back-to-back words.
    send(8'h64, 8'h07, 1);
    send(8'hFF, 8'h10, 1);
    send(8'h01, 8'h01, 1);
    send(8'h00, 8'h03, 1);
    drain(200, 1'b0);
    chk("pops_5", pop_cnt, 32'd5);
    chk("pushes_5", push_cnt, 32'd5);
    chk("txn_cnt_5", 32'(txn_cnt), 32'd5);

    // Output FIFO full around dut_done: HOLD, no new pop, push right after not_full rises.
    v0 = vcnt;
    send(8'h64, 8'h07, 5);
    wait_valid(v0);
    not_full = 1'b0;
    p0 = pop_cnt;
    send(8'h30, 8'h06, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 5) chk("hold_odata", 32'(odata), 32'h020E);
    end
    chk("hold_no_pop", pop_cnt, p0);
    not_full = 1'b1;
    rise = cyc;
    repeat (2) step();
    chk("hold_push_time", last_push_cyc, rise + 1);
    drain(200, 1'b0);

    // dut_done coinciding with watchdog expiry, then a hang, then a good word.
    send(8'h64, 8'h07, TO);
    send(8'h12, 8'h34, 0);
    send(8'hFF, 8'h10, 2);
    drain(300, 1'b0);
    chk("err_sticky", 32'(err_timeout), 32'd1);

    // Zero divisor.
    v0 = vcnt;
    send(8'h2A, 8'h00, 2);
    drain(100, 1'b0);
    chk("zero_div_valids", vcnt - v0, BYP ? 32'd0 : 32'd1);

    // Randomized traffic with a busy output FIFO.
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      r = int'($urandom_range(0, 9));
      l = (r == 0) ? 0 : (r == 1) ? TO + 1 : (r == 2) ? TO : int'($urandom_range(1, 5));
      send(a, b, l);
    end
    drain(4000, 1'b1);
    chk("txn_cnt_rand", 32'(txn_cnt), 32'(npush));

    // Reset while waiting on the divider; the late dut_done must be ignored.
    v0 = vcnt;
    send(8'h64, 8'h07, 6);
    wait_valid(v0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    dq.delete();
    vq.delete();
    sticky = 1'b0;
    npush = 0;
    chk_reset_vals("midreset");
    p0 = push_cnt;
    repeat (10) step();
    chk("midreset_no_push", push_cnt, p0);
    chk("midreset_txn_cnt", 32'(txn_cnt), 32'd0);
    send(8'h0F, 8'h05, 2);
    drain(100, 1'b0);
    chk("recover_txn_cnt", 32'(txn_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/div_fifo_harness.md
# div_fifo_harness

Parametrised FIFO-to-divider harness: pops packed operand words from an input FIFO, issues each to an external integer divider over a valid/done handshake, and pushes packed {remainder, quotient} results to an output FIFO. It replaces the fixed 8-bit harness in the test-harness pcore and adds:
- operand width generalisation;
- a divider watchdog timeout;
- a transaction counter;
- optional divide-by-zero bypass.

## Interface

Parameters:
- W, 8, operand width; dividend, divisor, quotient and remainder are each W bits; legal 4..32.
- TIMEOUT, 64, max cycles spent in WAIT before the watchdog fires; legal 2..65535.
- CNT_W, 16, width of txn_cnt.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- idata  in  2W  input FIFO data, {dividend[2W-1:W], divisor[W-1:0]}, valid the cycle after pop.
- rdy  in  1  input FIFO not empty.
- not_full  in  1  output FIFO can accept a word.
- pop  out  1  input FIFO read strobe, registered, one-cycle pulse.
- push  out  1  output FIFO write strobe, registered, one-cycle pulse.
- odata  out  2W  result {remainder[2W-1:W], quotient[W-1:0]}, registered, held between captures.
- dut_valid  out  1  issue strobe to divider, high exactly one cycle per transaction.
- dut_dividend  out  W  registered operand, stable from issue until next LOAD.
- dut_divisor  out  W  registered operand, as above.
- dut_done  in  1  divider result valid, one-cycle pulse.
- dut_quotient  in  W  sampled when dut_done.
- dut_remainder  in  W  sampled when dut_done.
- err_timeout  out  1  sticky watchdog flag.
- txn_cnt  out  CNT_W  count of pushed results, wraps modulo 2^CNT_W.

## Operation

- Reset values: pop=0, push=0, odata=0, dut_valid=0, dut_dividend=0, dut_divisor=0, err_timeout=0, txn_cnt=0, state=IDLE, watchdog=0.
- States IDLE, LOAD, ISSUE, WAIT, HOLD; 3-bit encoded; illegal codes go to IDLE.
- IDLE: if rdy & not_full, assert pop next cycle and go to LOAD; otherwise stay.
- LOAD: capture idata into dut_dividend/dut_divisor; go to ISSUE.
- ISSUE:
  - dut_valid=1 (decoded from state flop); clear watchdog; go to WAIT.
  - With bypass compiled in, see Configuration.
- WAIT:
  - Watchdog increments every cycle.
  - On dut_done, capture {dut_remainder, dut_quotient} into odata.
  - On watchdog reaching TIMEOUT-1 without dut_done, load odata with all-ones and set err_timeout.
  - If dut_done and the timeout coincide, dut_done wins and err_timeout is not set.
  - After either event: if not_full, assert push next cycle and go to IDLE; else go to HOLD.
- HOLD: when not_full, assert push next cycle and go to IDLE.
- txn_cnt increments in the cycle push is high.
- dut_done outside WAIT is ignored.
- rdy is ignored outside IDLE.
- err_timeout clears only on reset.
- Reset mid-operation abandons the transaction: no push occurs, and a later dut_done is ignored.

## Timing

- pop at cycle T; operands captured at T+1; dut_valid at T+2; WAIT entered T+3.
- dut_done arriving at cycle D (D≥T+3) gives push at D+1 when not_full; minimum pop-to-push latency 4 cycles.
- The next pop may assert in the cycle after push (the IDLE cycle with push high evaluates rdy & not_full).
- Throughput with single-cycle divider and free FIFOs: one result per 5 cycles.
- odata is stable from capture through the push cycle and until the next capture.
- Timeout push at T+3+TIMEOUT when not_full.

## Configuration

- DIV_ZERO_BYPASS_EN defined:
  - In ISSUE, a divisor of zero suppresses dut_valid.
  - odata is loaded with {dividend, all-ones quotient}.
  - The FSM goes straight to the push/HOLD decision, so pop-to-push is 3 cycles and the watchdog is not started.
- DIV_ZERO_BYPASS_EN undefined: zero divisors are issued to the divider like any other operand; the result is whatever the divider returns, or the timeout value.

## Test plan

- W=8, idata=0x6407, 3-cycle divider, FIFOs free -> one pop, dut_valid 2 cycles later with 100/7, odata=0x020E, push 1 cycle after dut_done, txn_cnt=1.
- 4 back-to-back words (0x6407, 0xFF10, 0x0101, 0x0003) -> results 0x020E, 0x0F0F, 0x0001, 0x0000 pushed in order; exactly 4 pops and 4 pushes; txn_cnt=4.
- not_full low for 10 cycles around dut_done -> HOLD, odata stable, push exactly 1 cycle after not_full rises, no further pop meanwhile.
- TIMEOUT=8, divider never responds -> push with odata=0xFFFF at 8 cycles after WAIT entry, err_timeout=1 and stays 1 for the following good transaction.
- With DIV_ZERO_BYPASS_EN, idata=0x2A00 -> no dut_valid, odata=0x2AFF pushed 3 cycles after pop.
- Without DIV_ZERO_BYPASS_EN, same idata -> dut_valid issued.
- reset asserted in WAIT, then dut_done pulses -> no push, all outputs at reset values, FSM in IDLE.
